sel_rr_arbiter: RTL and testbench
=================================

Name: sel_rr_arbiter

Overview:
Two-source round-robin arbiter that sits directly upstream of the 2:1 selector and produces its `sel` control. It accepts two valid/ready request streams and picks one per transfer, alternating fairly between them. The winning payload goes into a one-entry output register, and `sel` reports which source that registered beat came from. Throughput is one beat per cycle; latency is one cycle.

Parameters:
- WIDTH, 8, payload width of each source and of the output.

Ports:
- clk  input  1  system clock; rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in0_valid  input  1  source 0 has a beat.
- in0_data  input  WIDTH  source 0 payload.
- in0_ready  output  1  source 0 beat accepted this cycle.
- in1_valid  input  1  source 1 has a beat.
- in1_data  input  WIDTH  source 1 payload.
- in1_ready  output  1  source 1 beat accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered payload.
- out_ready  input  1  consumer takes the beat this cycle.
- sel  output  1  source of the current out_data (0 = in0, 1 = in1); drives the selector.

Behaviour:
- Reset: one clock, `clk`; reset is asynchronous and active-low on `rst_n`. While `rst_n` = 0:
  - out_valid = 0, out_data = 0, sel = 0, in0_ready = in1_ready = 0.
  - Internal last_grant = 1, so source 0 wins the first tie.
- Reset mid-transfer: the held beat is dropped with no handshake; operation resumes from the reset state on the first edge after release.
- FSM, encoded by out_valid:
  - EMPTY (out_valid = 0).
  - FULL (out_valid = 1).
- load_en = !out_valid || out_ready (combinational).
- Grant, combinational:
  - Only one valid: that source wins.
  - Both valid: the source != last_grant wins.
  - Neither valid: no grant.
- inX_ready = load_en && (winner == X).
  - Never both high in the same cycle.
  - Depends combinationally on both valids and on out_ready.
  - Sources must not make valid depend on ready.
- Rising edge with load_en = 1 and a winner:
  - out_data <= winner data, sel <= winner, last_grant <= winner, out_valid <= 1 (state FULL).
- Rising edge with load_en = 1 and no winner:
  - out_valid <= 0 (state EMPTY).
  - out_data and sel hold their last values.
- Rising edge with load_en = 0 (FULL && !out_ready):
  - All registers hold; out_data and sel are stable for as long as out_valid && !out_ready.
- Simultaneous drain and fill (FULL, out_ready = 1, a source valid): the new beat replaces the old on the same edge, so out_valid stays 1 with no bubble.
- Latency: a beat accepted at edge N appears on out_data after edge N.
- Fairness:
  - With both sources continuously valid and out_ready = 1, grants alternate 0, 1, 0, 1, ...
  - A source waits at most one grant to the other source.
- Single source: a lone valid source is granted every cycle; last_grant does not block it.
- sel changes only on a load edge, never combinationally.

Test Plan:
1. Reset: assert rst_n = 0 asynchronously mid-cycle -> out_valid, sel, out_data, both readys go to 0 immediately. Release with both sources valid (in0_data = 0x11, in1_data = 0x22), out_ready = 1 -> first beat 0x11 / sel = 0, then 0x22 / sel = 1, alternating.
2. Single source: in1_valid held 1 with data 0x01, 0x02, 0x03 over 3 cycles, in0_valid = 0, out_ready = 1 -> in1_ready = 1 every cycle; out_data = 0x01, 0x02, 0x03 on consecutive cycles; sel = 1 throughout.
3. Backpressure: FULL with 0x5A / sel = 0, out_ready = 0 for 4 cycles, both sources valid -> both readys 0; out_data = 0x5A and sel = 0 stable. Raise out_ready -> the in1 beat loads on that edge with no bubble.
4. Drain to empty: one beat 0xA5 from in0 then no valids, out_ready = 1 -> out_valid high for exactly 1 cycle, then 0; sel stays 0 and out_data stays 0xA5.
5. Reset mid-operation: pull rst_n low while FULL and stalled -> out_valid = 0 at once. After release, the first tie goes to in0 (sel = 0).
6. Random-valid fairness run: 1000 cycles, random valids and out_ready -> scoreboard checks per-source ordering is preserved, no beat is lost or duplicated, never both readys high, and no source is skipped twice in a row while valid.

Source files
------------

// File: rtl/sel_rr_arbiter.sv
// Two-source round-robin arbiter feeding a one-entry output register.
// sel reports which source the registered beat came from and drives the 2:1 selector.
//
// state | meaning
// EMPTY | output register holds no beat (out_valid = 0)
// FULL  | output register holds a beat (out_valid = 1)
module sel_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic             load_en;
  logic             any_valid;
  logic             winner;

  // On a tie the source that did not win last time takes the grant.
  always_comb begin
    any_valid = in0_valid || in1_valid;
    winner    = 1'b0;
    if (in0_valid && in1_valid) begin
      winner = ~last_q;
    end else if (in1_valid) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    load_en = 1'b0;

    case (state_q)
      EMPTY: load_en = 1'b1;
      FULL:  load_en = out_ready;
      default: load_en = 1'b1;
    endcase

    if (load_en) begin
      if (any_valid) begin
        state_d = FULL;
        data_d  = winner ? in1_data : in0_data;
        sel_d   = winner;
        last_d  = winner;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // Readies are forced low while reset is held so no beat is taken during reset.
  assign in0_ready = rst_n && load_en && any_valid && !winner;
  assign in1_ready = rst_n && load_en && any_valid && winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Directed and random self-checking bench for sel_rr_arbiter.
module tb_sel_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       in0_valid, in1_valid;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       sel;

  int tests = 0;
  int fails = 0;

  sel_rr_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".out_data"},  {24'd0, out_data},  {24'd0, d});
    chk({tag, ".sel"},       {31'd0, sel},       {31'd0, s});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".in0_ready"}, {31'd0, in0_ready}, {31'd0, r0});
    chk({tag, ".in1_ready"}, {31'd0, in1_ready}, {31'd0, r1});
  endtask

  logic [8:0] sb_q[$];
  logic [8:0] exp_beat;
  logic       v0, v1, r0, r1, acc0, acc1, ov, ordy, os;
  logic [7:0] od;
  logic [6:0] seq0, seq1;
  int         skip0, skip1;

  initial begin
    rst_n = 1'b0;
    in0_valid = 1'b0; in0_data = 8'h00;
    in1_valid = 1'b0; in1_data = 8'h00;
    out_ready = 1'b0;
    #3;
    chk_out("rst_init", 1'b0, 8'h00, 1'b0);
    chk_rdy("rst_init", 1'b0, 1'b0);
    #9 rst_n = 1'b1;

    // 1: preload so last_grant = 0, then async reset mid-cycle
    @(negedge clk);
    in0_valid = 1'b1; in0_data = 8'h99; out_ready = 1'b1;
    step();
    chk_out("t1_preload", 1'b1, 8'h99, 1'b0);
    in0_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_out("t1_async_rst", 1'b0, 8'h00, 1'b0);
    in0_valid = 1'b1; in0_data = 8'h11;
    in1_valid = 1'b1; in1_data = 8'h22;
    out_ready = 1'b1;
    #1;
    chk_rdy("t1_rdy_in_rst", 1'b0, 1'b0);
    step();
    chk_out("t1_hold_in_rst", 1'b0, 8'h00, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    chk_rdy("t1_first_tie", 1'b1, 1'b0);
    step();
    chk_out("t1_beat0", 1'b1, 8'h11, 1'b0);
    chk_rdy("t1_beat0", 1'b0, 1'b1);
    step();
    chk_out("t1_beat1", 1'b1, 8'h22, 1'b1);
    chk_rdy("t1_beat1", 1'b1, 1'b0);
    step();
    chk_out("t1_beat2", 1'b1, 8'h11, 1'b0);
    step();
    chk_out("t1_beat3", 1'b1, 8'h22, 1'b1);

    // 2: lone in1 source granted every cycle despite last_grant = 1
    in0_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in1_data = 8'(i);
      #1;
      chk_rdy("t2_lone", 1'b0, 1'b1);
      step();
      chk_out("t2_lone", 1'b1, 8'(i), 1'b1);
    end

    // 3: backpressure holds register, release loads in1 with no bubble
    in0_valid = 1'b1; in0_data = 8'h5A; in1_valid = 1'b0;
    step();
    chk_out("t3_fill", 1'b1, 8'h5A, 1'b0);
    out_ready = 1'b0;
    in0_data = 8'h66; in1_valid = 1'b1; in1_data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_rdy("t3_stall", 1'b0, 1'b0);
      step();
      chk_out("t3_stall", 1'b1, 8'h5A, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk_rdy("t3_release", 1'b0, 1'b1);
    step();
    chk_out("t3_release", 1'b1, 8'h77, 1'b1);

    // 4: single beat then drain to empty
    in0_valid = 1'b1; in0_data = 8'hA5; in1_valid = 1'b0;
    step();
    chk_out("t4_beat", 1'b1, 8'hA5, 1'b0);
    in0_valid = 1'b0;
    step();
    chk_out("t4_empty", 1'b0, 8'hA5, 1'b0);
    step();
    chk_out("t4_empty2", 1'b0, 8'hA5, 1'b0);

    // 5: reset while FULL and stalled
    in0_valid = 1'b1; in0_data = 8'h3C;
    in1_valid = 1'b1; in1_data = 8'h4B;
    step();
    chk_out("t5_fill", 1'b1, 8'h4B, 1'b1);
    out_ready = 1'b0;
    step();
    chk_out("t5_stall", 1'b1, 8'h4B, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_out("t5_rst", 1'b0, 8'h00, 1'b0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk_rdy("t5_tie", 1'b1, 1'b0);
    step();
    chk_out("t5_after", 1'b1, 8'h3C, 1'b0);

    // 6: random valids and out_ready with scoreboard
    in0_valid = 1'b0; in1_valid = 1'b0;
    step();
    chk_out("t6_start", 1'b0, 8'h3C, 1'b0);
    v0 = 1'b0; v1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    seq0 = 7'd0; seq1 = 7'd0; skip0 = 0; skip1 = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (acc0) seq0 = seq0 + 7'd1;
      if (acc1) seq1 = seq1 + 7'd1;
      if (!v0 || acc0) v0 = ($urandom_range(0, 99) < 60);
      if (!v1 || acc1) v1 = ($urandom_range(0, 99) < 60);
      in0_valid = v0; in0_data = {1'b0, seq0};
      in1_valid = v1; in1_data = {1'b1, seq1};
      ordy = ($urandom_range(0, 99) < 70);
      out_ready = ordy;
      #1;
      r0 = in0_ready; r1 = in1_ready;
      ov = out_valid; od = out_data; os = sel;
      chk("t6_one_ready", {31'd0, (r0 && r1)}, 32'd0);
      chk("t6_out_valid", {31'd0, ov}, {31'd0, (sb_q.size() != 0)});
      if (ov && ordy && sb_q.size() != 0) begin
        exp_beat = sb_q.pop_front();
        chk("t6_beat", {23'd0, os, od}, {23'd0, exp_beat});
      end
      if ((!ov || ordy) && (v0 || v1))
        chk("t6_no_stall", {31'd0, (r0 || r1)}, 32'd1);
      acc0 = r0 && v0;
      acc1 = r1 && v1;
      if (acc0) sb_q.push_back({1'b0, 1'b0, seq0});
      if (acc1) sb_q.push_back({1'b1, 1'b1, seq1});
      if (acc0) skip0 = 0; else if (v0 && acc1) skip0++;
      if (acc1) skip1 = 0; else if (v1 && acc0) skip1++;
      if (acc0 || acc1)
        chk("t6_fair", {31'd0, (skip0 > 1 || skip1 > 1)}, 32'd0);
      step();
    end
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    #1;
    if (out_valid && sb_q.size() != 0) begin
      exp_beat = sb_q.pop_front();
      chk("t6_final_beat", {23'd0, sel, out_data}, {23'd0, exp_beat});
    end
    step();
    chk("t6_drained", {31'd0, out_valid}, 32'd0);
    chk("t6_sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
